// File: rtl/add_seq_ctrl_if.sv
// Operand/result handshake bundle for add_seq_ctrl.
// Optional sub input present when ADD_SEQ_SUB_EN is defined.
interface add_seq_ctrl_if #(
  parameter int WIDTH = 128
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADD_SEQ_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADD_SEQ_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

  modport master (
    output in_valid, a, b, cin,
`ifdef ADD_SEQ_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder: one 4-bit slice adder stepped LSB first.
// ADD_SEQ_SUB_EN adds a sub input (A - B - borrow, cin as borrow).
module add_seq_ctrl #(
  parameter int WIDTH = 128
) (
  input logic           clk,
  input logic           rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic [3:0]       a_nib, b_nib;
  logic [4:0]       slice;
  logic [3:0]       part;

`ifdef ADD_SEQ_SUB_EN
  assign b_in = bus.sub ? ~bus.b : bus.b;
  assign c_in = bus.sub ? ~bus.cin : bus.cin;
`else
  assign b_in = bus.b;
  assign c_in = bus.cin;
`endif

  assign a_nib = a_q[{idx_q, 2'b00} +: 4];
  assign b_nib = b_q[{idx_q, 2'b00} +: 4];
  assign slice = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, carry_q};
  // carry into the nibble's top bit, for signed overflow on the last step
  assign part  = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, carry_q};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = b_in;
          carry_d = c_in;
          idx_d   = '0;
          sum_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = slice[3:0];
        carry_d = slice[4];
        if (idx_q == LAST) begin
          cout_d  = slice[4];
          ovf_d   = slice[4] ^ part[3];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized self-checking bench for add_seq_ctrl against an
// arithmetic reference model (whole-word add/subtract).
module tb_add_seq_ctrl;
  localparam int W = 128;
  localparam int N = W / 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  add_seq_ctrl_if #(.WIDTH(W)) bus ();

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         ovf;
    logic         cout;
    logic [W-1:0] sum;
  } res_t;

  // whole-word reference: subtraction is A + ~B + ~borrow
  function automatic res_t model(logic [W-1:0] a, logic [W-1:0] b,
                                 logic cin, logic sub);
    logic [W:0]   full;
    logic [W-1:0] bb;
    logic         c;
    res_t         r;
    bb = sub ? ~b : b;
    c  = sub ? ~cin : cin;
    full   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_ops(logic [W-1:0] a, logic [W-1:0] b,
                           logic cin, logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
`ifdef ADD_SEQ_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: sub ignored in add-only build");
`endif
  endtask

  // offer operands at a negedge; returns at the negedge after accept
  task automatic send(logic [W-1:0] a, logic [W-1:0] b,
                      logic cin, logic sub);
    int guard;
    @(negedge clk);
    drive_ops(a, b, cin, sub);
    bus.in_valid = 1'b1;
    guard = 0;
    while (!bus.in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck low");
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // counts edges after accept until out_valid; scrambles inputs meanwhile
  task automatic wait_result(output int cyc, output int rdy_seen);
    cyc = 0;
    rdy_seen = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.out_valid) break;
      if (bus.in_ready) rdy_seen++;
      bus.a = rnd();
      bus.b = rnd();
      bus.cin = 1'($urandom);
      bus.out_ready = 1'($urandom);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic take();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b sum=%h c=%b o=%b, need 1 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf);
    end
  endtask

  task automatic test_simple();
    int cyc, rs;
    send(128'h5, 128'h3, 1'b0, 1'b0);
    wait_result(cyc, rs);
    checks++;
    if (cyc !== N) begin
      errors++;
      $display("FAIL latency: got %0d cycles, need %0d", cyc, N);
    end
    checks++;
    if (rs !== 0) begin
      errors++;
      $display("FAIL run_in_ready: in_ready high %0d times, need 0", rs);
    end
    checks++;
    if (bus.sum !== 128'h8 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL simple_add: sum=%h c=%b o=%b, need 8 0 0",
               bus.sum, bus.cout, bus.ovf);
    end
    take();
  endtask

  task automatic test_directed();
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    logic         cv[4];
    logic [W-1:0] es[4];
    logic         ec[4];
    logic         eo[4];
    int cyc, rs;
    av = '{{W{1'b1}}, {W{1'b1}}, {1'b0, {(W-1){1'b1}}}, {1'b1, {(W-1){1'b0}}}};
    bv = '{128'h1, 128'h0, 128'h1, {1'b1, {(W-1){1'b0}}}};
    cv = '{1'b0, 1'b1, 1'b0, 1'b0};
    es = '{128'h0, 128'h0, {1'b1, {(W-1){1'b0}}}, 128'h0};
    ec = '{1'b1, 1'b1, 1'b0, 1'b1};
    eo = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      send(av[i], bv[i], cv[i], 1'b0);
      wait_result(cyc, rs);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.sum !== es[i] ||
          bus.cout !== ec[i] || bus.ovf !== eo[i]) begin
        errors++;
        $display("FAIL directed_%0d: v=%b sum=%h c=%b o=%b, need 1 %h %b %b",
                 i, bus.out_valid, bus.sum, bus.cout, bus.ovf,
                 es[i], ec[i], eo[i]);
      end
      take();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic cin;
    res_t e;
    int cyc, rs;
    for (int i = 0; i < 20; i++) begin
      a = rnd();
      b = rnd();
      if (i % 5 == 1) b = ~a;
      cin = 1'($urandom);
      e = model(a, b, cin, 1'b0);
      send(a, b, cin, 1'b0);
      wait_result(cyc, rs);
      checks++;
      if (cyc !== N || bus.sum !== e.sum || bus.cout !== e.cout ||
          bus.ovf !== e.ovf) begin
        errors++;
        $display("FAIL random_%0d: cyc=%0d sum=%h c=%b o=%b, need %0d %h %b %b",
                 i, cyc, bus.sum, bus.cout, bus.ovf, N, e.sum, e.cout, e.ovf);
      end
      take();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2;
    res_t e1, e2;
    int cyc, rs, bad;
    a1 = rnd(); b1 = rnd();
    a2 = rnd(); b2 = rnd();
    e1 = model(a1, b1, 1'b1, 1'b0);
    e2 = model(a2, b2, 1'b0, 1'b0);
    send(a1, b1, 1'b1, 1'b0);
    wait_result(cyc, rs);
    drive_ops(a2, b2, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.sum !== e1.sum || bus.cout !== e1.cout) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL backpressure_hold: %0d bad cycles, need 0", bad);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release: rdy=%b vld=%b, need 1 0",
               bus.in_ready, bus.out_valid);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result(cyc, rs);
    checks++;
    if (cyc !== N || bus.sum !== e2.sum || bus.cout !== e2.cout ||
        bus.ovf !== e2.ovf) begin
      errors++;
      $display("FAIL backpressure_next: cyc=%0d sum=%h, need %0d %h",
               cyc, bus.sum, N, e2.sum);
    end
    take();
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    send({W{1'b1}}, {W{1'b1}}, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
        bus.sum !== '0 || bus.cout !== 1'b0 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: rdy=%b vld=%b sum=%h, need 1 0 0",
               bus.in_ready, bus.out_valid, bus.sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_abort: %0d bad cycles after release, need 0", pulses);
    end
  endtask

`ifdef ADD_SEQ_SUB_EN
  task automatic test_sub();
    logic [W-1:0] a, b;
    logic cin;
    res_t e;
    int cyc, rs;
    send(128'd10, 128'd3, 1'b0, 1'b1);
    wait_result(cyc, rs);
    checks++;
    if (bus.sum !== 128'd7 || bus.cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_10_3: sum=%h c=%b, need 7 1", bus.sum, bus.cout);
    end
    take();
    send(128'd3, 128'd10, 1'b0, 1'b1);
    wait_result(cyc, rs);
    checks++;
    if (bus.sum !== ({W{1'b1}} - 128'd6) || bus.cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_3_10: sum=%h c=%b, need -7 0", bus.sum, bus.cout);
    end
    take();
    for (int i = 0; i < 10; i++) begin
      a = rnd();
      b = rnd();
      cin = 1'($urandom);
      e = model(a, b, cin, 1'b1);
      send(a, b, cin, 1'b1);
      wait_result(cyc, rs);
      checks++;
      if (bus.sum !== e.sum || bus.cout !== e.cout || bus.ovf !== e.ovf) begin
        errors++;
        $display("FAIL sub_rand_%0d: sum=%h c=%b o=%b, need %h %b %b",
                 i, bus.sum, bus.cout, bus.ovf, e.sum, e.cout, e.ovf);
      end
      take();
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive_ops('0, '0, 1'b0, 1'b0);
    #23;
    test_reset();
    rst_n = 1'b1;
    test_simple();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
`ifdef ADD_SEQ_SUB_EN
    test_sub();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
